// File: rtl/leaf_best_match_if.sv
// Bus bundle for leaf_best_match: query handshake, leaf patch memory read port
// and result handshake.
interface leaf_best_match_if #(
   parameter int PATCH_WIDTH   = 55,
   parameter int ADDRESS_WIDTH = 8,
   parameter int LEAF_SIZE_LOG = 3,
   parameter int DIST_WIDTH    = 25
);
   logic                                   query_valid;
   logic                                   query_ready;
   logic [ADDRESS_WIDTH-1:0]               leaf_index;
   logic [PATCH_WIDTH-1:0]                 patch_in;
   logic                                   mem_ren;
   logic [ADDRESS_WIDTH+LEAF_SIZE_LOG-1:0] mem_addr;
   logic [PATCH_WIDTH-1:0]                 mem_rdata;
   logic                                   out_valid;
   logic                                   out_ready;
   logic [ADDRESS_WIDTH+LEAF_SIZE_LOG-1:0] best_index;
   logic [DIST_WIDTH-1:0]                  best_dist;

   modport slave (
      input  query_valid, leaf_index, patch_in, mem_rdata, out_ready,
      output query_ready, mem_ren, mem_addr, out_valid, best_index, best_dist
   );

   modport master (
      output query_valid, leaf_index, patch_in, mem_rdata, out_ready,
      input  query_ready, mem_ren, mem_addr, out_valid, best_index, best_dist
   );
endinterface

// File: rtl/leaf_best_match.sv
// Leaf search: reads all candidate patches of one leaf and reports the index and
// squared L2 distance of the nearest one to the query patch.
module leaf_best_match #(
   parameter int PATCH_WIDTH   = 55,
   parameter int DSIZE         = 11,
   parameter int COMPONENTS    = 5,
   parameter int ADDRESS_WIDTH = 8,
   parameter int LEAF_SIZE_LOG = 3,
   parameter int DIST_WIDTH    = 25
) (
   input  logic              clk,
   input  logic              rst_n,
   leaf_best_match_if.slave  bus
);
   localparam int LEAF_SIZE = 1 << LEAF_SIZE_LOG;
   localparam int IDX_W     = ADDRESS_WIDTH + LEAF_SIZE_LOG;

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t                     state_q, state_d;
   logic [LEAF_SIZE_LOG-1:0]   slot_q, slot_d;
   logic [LEAF_SIZE_LOG-1:0]   rd_slot_q, rd_slot_d;
   logic                       rd_valid_q, rd_valid_d;
   logic [ADDRESS_WIDTH-1:0]   leaf_q, leaf_d;
   logic [PATCH_WIDTH-1:0]     query_q, query_d;
   logic [IDX_W-1:0]           best_index_q, best_index_d;
   logic [DIST_WIDTH-1:0]      best_dist_q, best_dist_d;
   logic [DIST_WIDTH-1:0]      cand_dist;
   logic                       fetch;

   // Components are sign-extended by one bit so the difference cannot overflow;
   // the square is non-negative and fits the accumulator without saturation.
   function automatic logic [DIST_WIDTH-1:0] sq_dist(input logic [PATCH_WIDTH-1:0] cand,
                                                     input logic [PATCH_WIDTH-1:0] qry);
      logic signed [DSIZE:0]       diff;
      logic signed [2*DSIZE+1:0]   prod;
      logic [DIST_WIDTH-1:0]       acc;
      acc = '0;
      for (int k = 0; k < COMPONENTS; k++) begin
         diff = $signed({cand[k*DSIZE+DSIZE-1], cand[k*DSIZE +: DSIZE]})
              - $signed({qry[k*DSIZE+DSIZE-1], qry[k*DSIZE +: DSIZE]});
         prod = diff * diff;
         acc  = acc + DIST_WIDTH'($unsigned(prod));
      end
      return acc;
   endfunction

   assign fetch = (state_q == FETCH);

   always_comb begin
      state_d      = state_q;
      slot_d       = slot_q;
      leaf_d       = leaf_q;
      query_d      = query_q;
      rd_valid_d   = fetch;
      rd_slot_d    = slot_q;
      best_index_d = best_index_q;
      best_dist_d  = best_dist_q;
      cand_dist    = sq_dist(bus.mem_rdata, query_q);

      case (state_q)
         IDLE: begin
            if (bus.query_valid) begin
               leaf_d  = bus.leaf_index;
               query_d = bus.patch_in;
               slot_d  = '0;
               state_d = FETCH;
            end
         end
         FETCH: begin
            slot_d = slot_q + 1'b1;
            if (slot_q == LEAF_SIZE_LOG'(LEAF_SIZE - 1)) state_d = DRAIN;
         end
         DRAIN:   state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase

      // Strict compare keeps the lower slot on a tie; slot 0 always seeds the best.
      if (rd_valid_q && ((rd_slot_q == '0) || (cand_dist < best_dist_q))) begin
         best_index_d = {leaf_q, rd_slot_q};
         best_dist_d  = cand_dist;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         slot_q       <= '0;
         rd_valid_q   <= 1'b0;
         rd_slot_q    <= '0;
         best_index_q <= '0;
         best_dist_q  <= '0;
      end else begin
         state_q      <= state_d;
         slot_q       <= slot_d;
         rd_valid_q   <= rd_valid_d;
         rd_slot_q    <= rd_slot_d;
         best_index_q <= best_index_d;
         best_dist_q  <= best_dist_d;
      end
   end

   // Latched query data only matters while a search is in flight, so it needs no reset.
   always_ff @(posedge clk) begin
      leaf_q  <= leaf_d;
      query_q <= query_d;
   end

   assign bus.query_ready = rst_n && (state_q == IDLE);
   assign bus.mem_ren     = fetch;
   assign bus.mem_addr    = fetch ? {leaf_q, slot_q} : '0;
   assign bus.out_valid   = (state_q == DONE);
   assign bus.best_index  = best_index_q;
   assign bus.best_dist   = best_dist_q;
endmodule

// File: tb/tb_leaf_best_match.sv
// Directed bench for leaf_best_match with a cycle-level reference model and
// hand-computed expected results.
module tb_leaf_best_match;
   localparam int PW  = 55;
   localparam int DS  = 11;
   localparam int NC  = 5;
   localparam int AW  = 8;
   localparam int LSL = 3;
   localparam int LS  = 8;
   localparam int DW  = 25;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   leaf_best_match_if #(.PATCH_WIDTH(PW), .ADDRESS_WIDTH(AW), .LEAF_SIZE_LOG(LSL),
                        .DIST_WIDTH(DW)) bus();

   leaf_best_match #(.PATCH_WIDTH(PW), .DSIZE(DS), .COMPONENTS(NC), .ADDRESS_WIDTH(AW),
                     .LEAF_SIZE_LOG(LSL), .DIST_WIDTH(DW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic [PW-1:0] mem [0:(1<<(AW+LSL))-1];

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [PW-1:0] mk(input int a, input int b, input int c, input int d, input int e);
      logic [PW-1:0] p;
      int v[NC];
      v = '{a, b, c, d, e};
      for (int k = 0; k < NC; k++) p[k*DS +: DS] = v[k][DS-1:0];
      return p;
   endfunction

   function automatic int comp(input logic [PW-1:0] p, input int k);
      logic signed [DS-1:0] c;
      c = p[k*DS +: DS];
      return int'(c);
   endfunction

   function automatic longint pdist(input logic [PW-1:0] a, input logic [PW-1:0] b);
      longint s = 0;
      for (int k = 0; k < NC; k++) begin
         longint d = longint'(comp(a, k) - comp(b, k));
         s += d * d;
      end
      return s;
   endfunction

   function automatic int best_slot(input int leaf, input logic [PW-1:0] q);
      int bs = 0;
      longint bd = pdist(mem[leaf*LS], q);
      for (int s = 1; s < LS; s++) begin
         if (pdist(mem[leaf*LS+s], q) < bd) begin
            bd = pdist(mem[leaf*LS+s], q);
            bs = s;
         end
      end
      return bs;
   endfunction

   // Reference timeline: m_k counts cycles since accept; reads for slots 0..7, then drain.
   bit     m_busy, m_done;
   int     m_k, m_leaf, m_exp_idx;
   longint m_exp_dist;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_busy <= 1'b0;
         m_done <= 1'b0;
         m_k    <= 0;
      end else if (!m_busy && !m_done && bus.query_valid) begin
         m_busy     <= 1'b1;
         m_k        <= 0;
         m_leaf     <= int'(bus.leaf_index);
         m_exp_idx  <= int'(bus.leaf_index) * LS + best_slot(int'(bus.leaf_index), bus.patch_in);
         m_exp_dist <= pdist(mem[int'(bus.leaf_index) * LS + best_slot(int'(bus.leaf_index), bus.patch_in)],
                             bus.patch_in);
      end else if (m_busy) begin
         if (m_k == LS) begin
            m_busy <= 1'b0;
            m_done <= 1'b1;
         end else begin
            m_k <= m_k + 1;
         end
      end else if (m_done && bus.out_ready) begin
         m_done <= 1'b0;
      end
   end

   initial begin : compare
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            chk("rst_query_ready", bus.query_ready, 0);
            chk("rst_mem_ren", bus.mem_ren, 0);
            chk("rst_mem_addr", bus.mem_addr, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_best_index", bus.best_index, 0);
            chk("rst_best_dist", bus.best_dist, 0);
         end else begin
            chk("query_ready", bus.query_ready, (!m_busy && !m_done) ? 1 : 0);
            chk("mem_ren", bus.mem_ren, (m_busy && m_k < LS) ? 1 : 0);
            chk("mem_addr", bus.mem_addr, (m_busy && m_k < LS) ? m_leaf * LS + m_k : 0);
            chk("out_valid", bus.out_valid, m_done ? 1 : 0);
            if (m_done) begin
               chk("best_index", bus.best_index, m_exp_idx);
               chk("best_dist", bus.best_dist, m_exp_dist);
            end
         end
      end
   end

   // Leaf memory: read data appears one cycle after the strobe, junk otherwise.
   initial begin : memory
      logic            r;
      logic [AW+LSL-1:0] a;
      forever begin
         @(posedge clk);
         r = bus.mem_ren;
         a = bus.mem_addr;
         #1;
         bus.mem_rdata = r ? mem[a] : PW'({$urandom(), $urandom()});
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_query(input int leaf, input logic [PW-1:0] q);
      bus.query_valid = 1'b1;
      bus.leaf_index  = AW'(leaf);
      bus.patch_in    = q;
   endtask

   // First tick is the accept edge; returns edges from accept to out_valid.
   task automatic wait_result(output int n);
      tick();
      bus.query_valid = 1'b0;
      bus.leaf_index  = AW'($urandom());
      bus.patch_in    = PW'({$urandom(), $urandom()});
      n = 0;
      while (n < 40 && !bus.out_valid) begin
         tick();
         n++;
      end
      if (!bus.out_valid) chk("result_timeout", 0, 1);
   endtask

   initial begin : stim
      int n;
      logic [PW-1:0] q;
      bus.query_valid = 1'b0;
      bus.leaf_index  = '0;
      bus.patch_in    = '0;
      bus.out_ready   = 1'b1;
      bus.mem_rdata   = '0;
      for (int i = 0; i < (1<<(AW+LSL)); i++) mem[i] = '0;

      #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(negedge clk);
      chk("ready_after_release", bus.query_ready, 1);
      tick();

      // Exact match in slot 5 of leaf 63
      q = mk(251, -26, -1, -88, 79);
      for (int s = 0; s < LS; s++) mem[63*LS+s] = (s == 5) ? q : mk(10*s+1, -5, 7, 0, s);
      start_query(63, q);
      wait_result(n);
      chk("exact_latency", n, 9);
      chk("exact_index", bus.best_index, 509);
      chk("exact_dist", bus.best_dist, 0);
      tick();

      // Tie between slots 1 and 6
      for (int s = 0; s < LS; s++)
         mem[2*LS+s] = (s == 1 || s == 6) ? mk(1, 0, 0, 0, 0) : mk(5, 5, 5, 5, 5);
      start_query(2, '0);
      wait_result(n);
      chk("tie_latency", n, 9);
      chk("tie_index", bus.best_index, 17);
      chk("tie_dist", bus.best_dist, 1);
      tick();

      // Maximum distance
      for (int s = 0; s < LS; s++) mem[10*LS+s] = mk(-1024, -1024, -1024, -1024, -1024);
      start_query(10, mk(1023, 1023, 1023, 1023, 1023));
      wait_result(n);
      chk("max_index", bus.best_index, 80);
      chk("max_dist", bus.best_dist, 20951045);
      tick();

      // Backpressure with a query waiting
      for (int s = 0; s < LS; s++) mem[200*LS+s] = mk(37*s-100, -50*s, 250, s-400, 480+3*s);
      bus.out_ready = 1'b0;
      start_query(200, mk(100, -200, 300, -400, 500));
      wait_result(n);
      chk("bp_latency", n, 9);
      for (int i = 0; i < 5; i++) begin
         start_query(2, '0);
         tick();
         chk("bp_hold_ready", bus.query_ready, 0);
         chk("bp_hold_valid", bus.out_valid, 1);
      end
      bus.out_ready = 1'b1;
      tick();
      chk("bp_release_ready", bus.query_ready, 1);
      chk("bp_release_valid", bus.out_valid, 0);
      wait_result(n);
      chk("bp_next_latency", n, 9);
      chk("bp_next_index", bus.best_index, 17);
      chk("bp_next_dist", bus.best_dist, 1);
      tick();

      // Reset during slot 3 of a fetch whose best so far is an exact match
      for (int s = 0; s < LS; s++) mem[4*LS+s] = (s == 1) ? '0 : mk(50, 50, 0, 0, 0);
      for (int s = 0; s < LS; s++) mem[5*LS+s] = mk(s+3, 0, 0, 0, 0);
      start_query(4, '0);
      tick();
      bus.query_valid = 1'b0;
      repeat (3) tick();
      chk("abort_addr", bus.mem_addr, 35);
      rst_n = 1'b0;
      #1;
      chk("abort_mem_ren", bus.mem_ren, 0);
      chk("abort_out_valid", bus.out_valid, 0);
      chk("abort_best_dist", bus.best_dist, 0);
      tick();
      tick();
      rst_n = 1'b1;
      tick();
      chk("abort_ready", bus.query_ready, 1);
      start_query(5, '0);
      wait_result(n);
      chk("after_abort_latency", n, 9);
      chk("after_abort_index", bus.best_index, 40);
      chk("after_abort_dist", bus.best_dist, 9);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
